// File: rtl/debounced_digit_counter.sv
// rtl/debounced_digit_counter.sv - debounced push-button stepping a 4-bit digit up/down
// Optional hold-to-repeat stepping is compiled in when DIGIT_COUNTER_REPEAT_EN is defined.
module debounced_digit_counter #(
  parameter int DEBOUNCE_LIMIT = 10,
  parameter int MAX_COUNT      = 15,
  parameter int HOLD_LIMIT     = 1000,
  parameter int REPEAT_LIMIT   = 250
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  input  logic       i_Dir,
  output logic [3:0] o_Binary_Num,
  output logic       o_EN,
  output logic       o_Step_Pulse
);

  // Elaboration-time range checks on the configuration.
  if (DEBOUNCE_LIMIT < 1 || DEBOUNCE_LIMIT > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_LIMIT must be 1..65535");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > 15) begin : g_bad_max
    $error("MAX_COUNT must be 1..15");
  end
  if (HOLD_LIMIT < 1 || REPEAT_LIMIT < 1) begin : g_bad_timing
    $error("HOLD_LIMIT and REPEAT_LIMIT must be at least 1");
  end

  localparam int              DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [3:0]      MAX_NUM = 4'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic            r_Sync1;
  logic            r_Sync2;
  logic            w_Sync;
  logic            r_State;
  logic [DB_W-1:0] r_Db_Cnt;
  state_t          r_Fsm;
  state_t          w_Fsm_Next;
  logic            w_Step;
  logic [3:0]      w_Next_Num;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Sync1 <= 1'b0;
      r_Sync2 <= 1'b0;
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
    end
  end

  assign w_Sync = r_Sync2;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State  <= 1'b0;
      r_Db_Cnt <= '0;
    end else if (w_Sync != r_State) begin
      if (r_Db_Cnt == DB_LAST) begin
        r_State  <= ~r_State;
        r_Db_Cnt <= '0;
      end else begin
        r_Db_Cnt <= r_Db_Cnt + 1'b1;
      end
    end else begin
      r_Db_Cnt <= '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Fsm <= IDLE;
    end else begin
      r_Fsm <= w_Fsm_Next;
    end
  end

`ifdef DIGIT_COUNTER_REPEAT_EN
  localparam int               TMR_MAX     = (HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT;
  localparam int               TMR_W       = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_LIMIT - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_LIMIT - 1);

  logic [TMR_W-1:0] r_Timer;
  logic             w_Timer_Clr;

  // Release is tested before timer expiry so a release never produces a step.
  always_comb begin
    w_Fsm_Next  = r_Fsm;
    w_Step      = 1'b0;
    w_Timer_Clr = 1'b0;
    case (r_Fsm)
      IDLE: begin
        if (r_State) begin
          w_Step      = 1'b1;
          w_Timer_Clr = 1'b1;
          w_Fsm_Next  = HELD;
        end
      end
      HELD: begin
        if (!r_State) begin
          w_Fsm_Next = IDLE;
        end else if (r_Timer == HOLD_LAST) begin
          w_Step      = 1'b1;
          w_Timer_Clr = 1'b1;
          w_Fsm_Next  = REPEAT;
        end
      end
      REPEAT: begin
        if (!r_State) begin
          w_Fsm_Next = IDLE;
        end else if (r_Timer == REPEAT_LAST) begin
          w_Step      = 1'b1;
          w_Timer_Clr = 1'b1;
        end
      end
      default: w_Fsm_Next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Timer <= '0;
    end else if (w_Timer_Clr || r_Fsm == IDLE) begin
      r_Timer <= '0;
    end else begin
      r_Timer <= r_Timer + 1'b1;
    end
  end
`else
  always_comb begin
    w_Fsm_Next = r_Fsm;
    w_Step     = 1'b0;
    case (r_Fsm)
      IDLE: begin
        if (r_State) begin
          w_Step     = 1'b1;
          w_Fsm_Next = HELD;
        end
      end
      HELD: begin
        if (!r_State) begin
          w_Fsm_Next = IDLE;
        end
      end
      default: w_Fsm_Next = IDLE;
    endcase
  end
`endif

  // Out-of-range digits fold back to 0 on an up step.
  always_comb begin
    w_Next_Num = o_Binary_Num;
    if (i_Dir) begin
      w_Next_Num = (o_Binary_Num == 4'd0) ? MAX_NUM : o_Binary_Num - 4'd1;
    end else begin
      w_Next_Num = (o_Binary_Num >= MAX_NUM) ? 4'd0 : o_Binary_Num + 4'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Binary_Num <= 4'd0;
      o_EN         <= 1'b0;
      o_Step_Pulse <= 1'b0;
    end else begin
      o_EN         <= 1'b1;
      o_Step_Pulse <= w_Step;
      if (w_Step) begin
        o_Binary_Num <= w_Next_Num;
      end
    end
  end

endmodule

// File: tb/tb_debounced_digit_counter.sv
// tb/tb_debounced_digit_counter.sv - directed checks of debounced_digit_counter
// Expected values follow DIGIT_COUNTER_REPEAT_EN when it is defined for the build.
module tb_debounced_digit_counter;

  logic       i_Clk;
  logic       i_Rst_L;
  logic       i_Switch;
  logic       i_Dir;
  logic [3:0] o_Binary_Num;
  logic       o_EN;
  logic       o_Step_Pulse;

  int n_cmp;
  int n_err;
  int pulse_total;
  int p_mark;

  debounced_digit_counter #(
    .DEBOUNCE_LIMIT(10),
    .MAX_COUNT     (9),
    .HOLD_LIMIT    (20),
    .REPEAT_LIMIT  (5)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Switch    (i_Switch),
    .i_Dir       (i_Dir),
    .o_Binary_Num(o_Binary_Num),
    .o_EN        (o_EN),
    .o_Step_Pulse(o_Step_Pulse)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    if (o_Step_Pulse === 1'b1) pulse_total++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Press held through the step edge (edge 12), then released and allowed to settle.
  task automatic press_release(input logic dir);
    i_Dir    = dir;
    i_Switch = 1'b1;
    tick(13);
    i_Switch = 1'b0;
    tick(13);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    pulse_total = 0;
    i_Rst_L     = 1'b0;
    i_Switch    = 1'b0;
    i_Dir       = 1'b0;

    tick(1);
    check("rst_num", o_Binary_Num, 0);
    check("rst_en", o_EN, 0);
    check("rst_pulse", o_Step_Pulse, 0);
    tick(2);
    check("rst3_num", o_Binary_Num, 0);
    check("rst3_en", o_EN, 0);
    i_Rst_L = 1'b1;
    tick(1);
    check("en_after_rst", o_EN, 1);
    check("num_after_rst", o_Binary_Num, 0);

    p_mark   = pulse_total;
    i_Switch = 1'b1;
    tick(11);
    check("press_e10_num", o_Binary_Num, 0);
    tick(1);
    check("press_e11_num", o_Binary_Num, 0);
    check("press_e11_pulse", o_Step_Pulse, 0);
    tick(1);
    check("press_e12_num", o_Binary_Num, 1);
    check("press_e12_pulse", o_Step_Pulse, 1);
    tick(1);
    check("press_e13_pulse", o_Step_Pulse, 0);
    i_Switch = 1'b0;
    tick(30);
    check("release_num", o_Binary_Num, 1);
    check("press_pulses", pulse_total - p_mark, 1);

    p_mark = pulse_total;
    for (int k = 0; k < 5; k++) begin
      i_Switch = 1'b1;
      tick(9);
      i_Switch = 1'b0;
      tick(3);
    end
    tick(20);
    check("bounce_num", o_Binary_Num, 1);
    check("bounce_pulses", pulse_total - p_mark, 0);

    i_Rst_L = 1'b0;
    tick(1);
    i_Rst_L = 1'b1;
    tick(1);
    check("wrap_start", o_Binary_Num, 0);
    for (int k = 1; k <= 10; k++) begin
      press_release(1'b0);
      check($sformatf("wrap_up_%0d", k), o_Binary_Num, k % 10);
    end
    press_release(1'b1);
    check("wrap_down", o_Binary_Num, 9);
    press_release(1'b1);
    check("down_again", o_Binary_Num, 8);

    i_Rst_L = 1'b0;
    tick(1);
    i_Rst_L = 1'b1;
    i_Dir   = 1'b0;
    tick(1);
    p_mark   = pulse_total;
    i_Switch = 1'b1;
    tick(13);
    check("hold_press_num", o_Binary_Num, 1);
    tick(19);
    check("hold_p19_num", o_Binary_Num, 1);
    tick(1);
`ifdef DIGIT_COUNTER_REPEAT_EN
    check("hold_p20_num", o_Binary_Num, 2);
    check("hold_p20_pulse", o_Step_Pulse, 1);
`else
    check("hold_p20_num", o_Binary_Num, 1);
    check("hold_p20_pulse", o_Step_Pulse, 0);
`endif
    tick(10);
    i_Switch = 1'b0;
    tick(10);
`ifdef DIGIT_COUNTER_REPEAT_EN
    check("hold_p40_num", o_Binary_Num, 6);
    check("hold_p40_pulse", o_Step_Pulse, 1);
`else
    check("hold_p40_num", o_Binary_Num, 1);
    check("hold_p40_pulse", o_Step_Pulse, 0);
`endif
    tick(20);
`ifdef DIGIT_COUNTER_REPEAT_EN
    check("hold_final_num", o_Binary_Num, 6);
    check("hold_pulses", pulse_total - p_mark, 6);
`else
    check("hold_final_num", o_Binary_Num, 1);
    check("hold_pulses", pulse_total - p_mark, 1);
`endif

    i_Switch = 1'b1;
    tick(35);
    i_Rst_L = 1'b0;
    tick(2);
    check("midrst_num", o_Binary_Num, 0);
    check("midrst_en", o_EN, 0);
    check("midrst_pulse", o_Step_Pulse, 0);
    i_Rst_L = 1'b1;
    p_mark  = pulse_total;
    tick(12);
    check("midrst_e11_num", o_Binary_Num, 0);
    check("midrst_e11_en", o_EN, 1);
    tick(1);
    check("midrst_e12_num", o_Binary_Num, 1);
    check("midrst_e12_pulse", o_Step_Pulse, 1);
    i_Switch = 1'b0;
    tick(30);
    check("midrst_final_num", o_Binary_Num, 1);
    check("midrst_pulses", pulse_total - p_mark, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounced_digit_counter.md
# debounced_digit_counter

Upstream stage for `Binary_To_7Segment`. It debounces a raw push-button and steps a 4-bit digit value up or down on each clean press. It drives the decoder's `i_Binary_Num` and `i_EN` inputs directly. Optionally, it auto-repeats while the button is held.

## Interface
- `DEBOUNCE_LIMIT`, default 10: consecutive cycles the synchronized input must differ from the debounced state before the debounced state flips; legal range 1..65535.
- `MAX_COUNT`, default 15: top value of the digit; legal range 1..15; wrap boundary in both directions.
- `HOLD_LIMIT`, default 1000: cycles the button must be held, after the press step, before the first auto-repeat step.
- `REPEAT_LIMIT`, default 250: cycles between subsequent auto-repeat steps.
- `i_Clk`  in  1  sole clock; all logic on rising edge.
- `i_Rst_L`  in  1  reset; one clock; reset is synchronous and active-low.
- `i_Switch`  in  1  raw button, active-high, asynchronous, bouncing.
- `i_Dir`  in  1  0 = count up, 1 = count down; sampled on the step cycle only.
- `o_Binary_Num`  out  4  current digit, to decoder `i_Binary_Num`.
- `o_EN`  out  1  display enable, to decoder `i_EN`.
- `o_Step_Pulse`  out  1  one-cycle strobe, high in the cycle `o_Binary_Num` takes a new value.

## Operation
- **Synchronizer:** 2 flops on `i_Switch` produce `w_Sync`.
- **Debounce:**
  - `r_State` holds the debounced level.
  - Counter width is `$clog2(DEBOUNCE_LIMIT+1)`.
  - Counter increments on each edge where `w_Sync != r_State`, and clears on any edge where they agree.
  - On the edge where a mismatch occurs with counter `== DEBOUNCE_LIMIT-1`, `r_State` flips and the counter clears.
- **Step generation FSM** (states IDLE, HELD, REPEAT):
  - IDLE: on rising edge of `r_State`, issue one step and go to HELD; load the hold timer with 0.
  - HELD: on `r_State == 0`, go to IDLE (no step). With `DIGIT_COUNTER_REPEAT_EN`, when the hold timer reaches `HOLD_LIMIT-1`, issue one step, go to REPEAT, and clear the timer.
  - REPEAT: on `r_State == 0`, go to IDLE. When the timer reaches `REPEAT_LIMIT-1`, issue one step and clear the timer.
- **Step arithmetic:**
  - Up: `MAX_COUNT` → 0, else +1.
  - Down: 0 → `MAX_COUNT`, else −1.
  - All other values are unreachable; if a value above `MAX_COUNT` is ever present, an up step yields 0.
- **Outputs:**
  - `o_Binary_Num` updates on the edge after the step is issued; `o_Step_Pulse` is high for exactly that cycle.
  - `o_EN` is 1 in every cycle following the first non-reset edge.
- **Outputs are registered;** there is no combinational input-to-output path.

## Timing
- **Reset value of every output** (`i_Rst_L` low at an edge): `o_Binary_Num = 0`, `o_EN = 0`, `o_Step_Pulse = 0`.
- **State cleared by reset:** synchronizer flops, `r_State`, debounce counter, hold timer, FSM = IDLE.
- **Press latency:**
  - Edge 0 is the first edge sampling `i_Switch` high, with the input stable from then on.
  - `r_State` rises at edge `DEBOUNCE_LIMIT+1`.
  - `o_Binary_Num` and `o_Step_Pulse` change at edge `DEBOUNCE_LIMIT+2`.
- **Release** follows the same latency; release never steps.
- **Bounce:** any glitch shorter than `DEBOUNCE_LIMIT` cycles (post-synchronizer) produces no change.
- **Auto-repeat timing:**
  - The first repeat pulse occurs `HOLD_LIMIT` cycles after the press pulse.
  - Each following pulse occurs `REPEAT_LIMIT` cycles after the previous one.
- **Release in the same cycle a timer expires:** release wins and no step is issued.
- **`i_Dir` changes mid-hold:** the next repeat step uses the new direction.
- **Reset mid-operation:** all state drops immediately at that edge.
  - A button held across reset release is seen as a new press.
  - That press steps once, `DEBOUNCE_LIMIT+2` edges after the first post-reset edge.

## Configuration
- **`DIGIT_COUNTER_REPEAT_EN` defined:** HELD→REPEAT auto-repeat is active as described above.
- **`DIGIT_COUNTER_REPEAT_EN` undefined:**
  - Hold/repeat timer logic is not compiled; `HOLD_LIMIT` and `REPEAT_LIMIT` are accepted but ignored.
  - The FSM never leaves HELD except on release, so exactly one step is issued per press regardless of hold length.

## Test plan
- **Reset:** `i_Rst_L=0` for 3 edges, then release → `o_Binary_Num=0`, `o_Step_Pulse=0` during reset; `o_EN=1` from the edge after release.
- **Clean press:** `DEBOUNCE_LIMIT=10`, `i_Dir=0`, `i_Switch` held high from edge 0 → single `o_Step_Pulse` and `o_Binary_Num=1` at edge 12; release adds no pulse.
- **Bounce rejection:** toggle `i_Switch` high for 9 cycles / low for 3, five times → `o_Binary_Num` stays 0 and `o_Step_Pulse` never asserts.
- **Wrap:**
  - `MAX_COUNT=9`: 10 clean up-presses from 0 → value sequence 1..9, then 0.
  - Then one press with `i_Dir=1` → 9.
- **Auto-repeat:** `HOLD_LIMIT=20`, `REPEAT_LIMIT=5`, button held 40 cycles after the press pulse.
  - With `DIGIT_COUNTER_REPEAT_EN`: pulses at press+0, +20, +25, +30, +35, +40 → value 6.
  - Without the macro: value 1.
- **Reset mid-hold:** button held, reset asserted for 2 edges during REPEAT, button still held → `o_Binary_Num=0`, then exactly one step to 1 at 12 edges after release.
